uart_loader: RTL and testbench

Boot-time program loader that sequences the UART byte receiver into instruction-memory writes. It takes the receiver's byte stream (8-bit data plus a one-cycle valid pulse) and parses a framed image: a 4-byte word count, N 4-byte data words, then a 1-byte XOR checksum. Each assembled word becomes a single-cycle memory write at consecutive addresses. The block sits between the receiver and the instruction-memory write port, and holds the core in reset until loading completes.

---
 rtl/uart_loader_pkg.sv | 27 ++
 rtl/uart_word_packer.sv | 52 +++++
 rtl/uart_loader.sv | 153 +++++++++++++++
 tb/tb_uart_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// +----------------------------------------------------------------------+
// | uart_loader_pkg : shared types and constants for the UART loader.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } loader_state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;
  // One packer serves both the header and data fields.
  localparam int PACK_BYTES = (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;

  localparam logic [7:0] CSUM_INIT = 8'h00;

endpackage

`default_nettype wire

// File: rtl/uart_word_packer.sv
// +----------------------------------------------------------------------+
// | uart_word_packer : big-endian byte-to-word assembler.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_word_packer
  import uart_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word_out,
  output logic        word_valid
);

  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic [23:0] shreg_q;
  logic [23:0] shreg_d;

  // The final byte bypasses the register so the word is usable in the same cycle.
  assign word_out   = {shreg_q, byte_in};
  assign word_valid = byte_valid && (idx_q == 2'(PACK_BYTES - 1));

  always_comb begin
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (clr) begin
      idx_d   = 2'd0;
      shreg_d = 24'd0;
    end else if (byte_valid) begin
      idx_d   = idx_q + 2'd1;
      shreg_d = {shreg_q[15:0], byte_in};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      idx_q   <= 2'd0;
      shreg_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_loader.sv
// +----------------------------------------------------------------------+
// | uart_loader : parses a framed UART image into instruction writes.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  core_rst_n
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  loader_state_t         state_q, state_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           wcnt_q, wcnt_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  crst_n_q, crst_n_d;

  logic                  pk_clr;
  logic                  pk_valid;
  logic [31:0]           pk_word;
  logic                  pk_word_valid;
  logic                  in_frame;

  assign in_frame = (state_q == S_HEADER) || (state_q == S_DATA);
  assign pk_clr   = !in_frame;
  assign pk_valid = rx_valid && in_frame;

  uart_word_packer u_packer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .clr        (pk_clr),
    .byte_in    (rx_data),
    .byte_valid (pk_valid),
    .word_out   (pk_word),
    .word_valid (pk_word_valid)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wcnt_d  = wcnt_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    // Address moves on the cycle after each strobe.
    addr_d  = we_q ? addr_q + 1'b1 : addr_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_HEADER;
          count_d = 32'd0;
          wcnt_d  = 32'd0;
          csum_d  = CSUM_INIT;
          addr_d  = '0;
        end
      end
      S_HEADER: begin
        if (pk_word_valid) begin
          count_d = pk_word;
          if ({1'b0, pk_word} > MAX_WORDS)
            state_d = S_ERROR;
          else if (pk_word == 32'd0)
            state_d = S_CHECK;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid)
          csum_d = csum_q ^ rx_data;
        if (pk_word_valid) begin
          we_d    = 1'b1;
          wdata_d = pk_word;
          wcnt_d  = wcnt_q + 32'd1;
          if (wcnt_q + 32'd1 == count_q)
            state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rx_valid)
          state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_HEADER) || (state_d == S_DATA) || (state_d == S_CHECK);
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_ERROR);
    crst_n_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      count_q  <= 32'd0;
      wcnt_q   <= 32'd0;
      csum_q   <= CSUM_INIT;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      crst_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wcnt_q   <= wcnt_d;
      csum_q   <= csum_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      crst_n_q <= crst_n_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign core_rst_n = crst_n_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_loader.sv
// +----------------------------------------------------------------------+
// | tb_uart_loader : directed self-checking bench for uart_loader.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_loader;

  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic          core_rst_n;

  int n_cmp = 0;
  int n_err = 0;
  int wr_total = 0;

  uart_loader #(.ADDR_WIDTH(AW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .core_rst_n (core_rst_n)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (mem_we === 1'b1) wr_total++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(); tick();
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b0, {AW{1'b0}}, 32'd0}) begin
      n_err++; $display("FAIL reset_mem: got we=%b addr=%h data=%h want 0/0/0", mem_we, mem_addr, mem_wdata);
    end
    n_cmp++; if ({busy, done, error, core_rst_n} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {busy, done, error, core_rst_n});
    end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    int w0;
    w0 = wr_total;
    send(8'h55); send(8'h66);               // ignored in IDLE
    n_cmp++; if (busy !== 1'b0 || wr_total != w0) begin
      n_err++; $display("FAIL idle_ignore: busy=%b writes=%0d want 0/0", busy, wr_total - w0);
    end
    do_start();
    n_cmp++; if ({busy, core_rst_n} !== 2'b10) begin
      n_err++; $display("FAIL normal_busy: got busy,crst=%b want 10", {busy, core_rst_n});
    end
    send_word(32'h0000_0002);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd0, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL normal_wr0: got we=%b addr=%h data=%h want 1/0/deadbeef", mem_we, mem_addr, mem_wdata);
    end
    send(8'h01);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 4'd1, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL normal_hold: got we=%b addr=%h data=%h want 0/1/deadbeef", mem_we, mem_addr, mem_wdata);
    end
    send(8'h23); send(8'h45); send(8'h67);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd1, 32'h01234567}) begin
      n_err++; $display("FAIL normal_wr1: got we=%b addr=%h data=%h want 1/1/01234567", mem_we, mem_addr, mem_wdata);
    end
    send(8'h22);                            // XOR of the eight data bytes
    n_cmp++; if ({busy, done, error, core_rst_n} !== 4'b0101) begin
      n_err++; $display("FAIL normal_done: got %b want 0101", {busy, done, error, core_rst_n});
    end
    n_cmp++; if (wr_total - w0 != 2) begin
      n_err++; $display("FAIL normal_count: got %0d writes want 2", wr_total - w0);
    end
  endtask

  task automatic test_start_in_done();
    int w0;
    w0 = wr_total;
    rx_data = 8'h00; rx_valid = 1'b1;       // byte with start is dropped
    do_start();
    rx_valid = 1'b0;
    send_word(32'h0000_0001);
    send_word(32'h1122_3344);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd0, 32'h11223344}) begin
      n_err++; $display("FAIL reload_wr: got we=%b addr=%h data=%h want 1/0/11223344", mem_we, mem_addr, mem_wdata);
    end
    send(8'h44);
    n_cmp++; if ({done, wr_total - w0} !== {1'b1, 32'd1}) begin
      n_err++; $display("FAIL reload_done: done=%b writes=%0d want 1/1", done, wr_total - w0);
    end
  endtask

  task automatic test_empty();
    int w0;
    w0 = wr_total;
    do_start();
    send_word(32'h0);
    n_cmp++; if ({busy, done} !== 2'b10) begin
      n_err++; $display("FAIL empty_check: busy,done=%b want 10", {busy, done});
    end
    send(8'h00);
    n_cmp++; if ({done, core_rst_n, wr_total - w0} !== {2'b11, 32'd0}) begin
      n_err++; $display("FAIL empty_done: done=%b crst=%b writes=%0d want 1/1/0", done, core_rst_n, wr_total - w0);
    end
    do_start();
    send_word(32'h0);
    send(8'h01);
    n_cmp++; if ({busy, done, error, core_rst_n} !== 4'b0010) begin
      n_err++; $display("FAIL empty_bad: got %b want 0010", {busy, done, error, core_rst_n});
    end
  endtask

  task automatic test_oversize();
    int w0;
    w0 = wr_total;
    do_start();
    send(8'h00); send(8'h00); send(8'h00);
    n_cmp++; if ({busy, error} !== 2'b10) begin
      n_err++; $display("FAIL over_pre: busy,error=%b want 10", {busy, error});
    end
    send(8'h11);
    n_cmp++; if ({busy, error} !== 2'b01) begin
      n_err++; $display("FAIL over_err: busy,error=%b want 01", {busy, error});
    end
    for (int i = 0; i < 6; i++) send(8'h00);
    n_cmp++; if ({error, busy, wr_total - w0} !== {2'b10, 32'd0}) begin
      n_err++; $display("FAIL over_ignore: error=%b busy=%b writes=%0d want 1/0/0", error, busy, wr_total - w0);
    end
  endtask

  task automatic test_full_capacity();
    int w0;
    w0 = wr_total;
    do_start();
    send_word(32'h0000_0010);
    for (int i = 0; i < 16; i++) send_word(32'(i));
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'hF, 32'h0000000F}) begin
      n_err++; $display("FAIL full_last: got we=%b addr=%h data=%h want 1/f/0000000f", mem_we, mem_addr, mem_wdata);
    end
    send(8'h00);                            // XOR of 0..15 is zero
    n_cmp++; if ({done, wr_total - w0} !== {1'b1, 32'd16}) begin
      n_err++; $display("FAIL full_done: done=%b writes=%0d want 1/16", done, wr_total - w0);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    logic [7:0] seq [9] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h04};
    w0 = wr_total;
    do_start();
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = seq[i];
      tick();
      if (i == 7) begin
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd0, 32'hA1B2C3D4}) begin
          n_err++; $display("FAIL b2b_wr: got we=%b addr=%h data=%h want 1/0/a1b2c3d4", mem_we, mem_addr, mem_wdata);
        end
      end
    end
    rx_valid = 1'b0;
    n_cmp++; if ({done, wr_total - w0} !== {1'b1, 32'd1}) begin
      n_err++; $display("FAIL b2b_done: done=%b writes=%0d want 1/1", done, wr_total - w0);
    end
  endtask

  task automatic test_start_during_data();
    int w0;
    w0 = wr_total;
    do_start();
    send_word(32'h0000_0001);
    start = 1'b1;
    send(8'h12); send(8'h34);
    start = 1'b0;
    send(8'h56); send(8'h78);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd0, 32'h12345678}) begin
      n_err++; $display("FAIL busy_start_wr: got we=%b addr=%h data=%h want 1/0/12345678", mem_we, mem_addr, mem_wdata);
    end
    send(8'h08);                            // 12^34^56^78
    n_cmp++; if ({done, wr_total - w0} !== {1'b1, 32'd1}) begin
      n_err++; $display("FAIL busy_start_done: done=%b writes=%0d want 1/1", done, wr_total - w0);
    end
  endtask

  task automatic test_reset_mid_word();
    int w0;
    w0 = wr_total;
    do_start();
    send_word(32'h0000_0001);
    send(8'hAA); send(8'hBB);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    n_cmp++; if ({mem_we, mem_addr, mem_wdata, busy, done, error, core_rst_n} !== {1'b0, 4'd0, 32'd0, 4'b0000}) begin
      n_err++; $display("FAIL midrst_out: we=%b addr=%h data=%h flags=%b want all reset", mem_we, mem_addr, mem_wdata, {busy, done, error, core_rst_n});
    end
    tick(); tick();
    n_cmp++; if (wr_total != w0) begin
      n_err++; $display("FAIL midrst_nowr: got %0d writes want 0", wr_total - w0);
    end
    do_start();
    send_word(32'h0000_0001);
    send_word(32'h5566_7788);
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd0, 32'h55667788}) begin
      n_err++; $display("FAIL midrst_wr: got we=%b addr=%h data=%h want 1/0/55667788", mem_we, mem_addr, mem_wdata);
    end
    send(8'hCC);                            // 55^66^77^88
    n_cmp++; if ({done, core_rst_n} !== 2'b11) begin
      n_err++; $display("FAIL midrst_done: done,crst=%b want 11", {done, core_rst_n});
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_start_in_done();
    test_empty();
    test_oversize();
    test_full_capacity();
    test_back_to_back();
    test_start_during_data();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
